biriscv_branch_predictor: RTL and testbench

//  Consumer of the execute-stage branch resolution interface (branch_request/taken/not_taken/

---
 rtl/biriscv_branch_predictor_if.sv | 31 +++
 rtl/biriscv_branch_predictor.sv | 139 +++++++++++++
 tb/tb_biriscv_branch_predictor.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/biriscv_branch_predictor_if.sv
// Branch predictor bundle: execute-stage resolution in, fetch PC in,
// predicted next fetch PC out. master = execute/fetch side, slave = predictor.
interface biriscv_branch_predictor_if;
   logic        branch_request_i;
   logic        branch_is_taken_i;
   logic        branch_is_not_taken_i;
   logic [31:0] branch_source_i;
   logic [31:0] branch_pc_i;
   logic        branch_is_call_i;
   logic        branch_is_ret_i;
   logic        branch_is_jmp_i;
   logic [31:0] pc_f_i;
   logic [31:0] next_pc_f_o;
   logic        next_taken_f_o;

   modport master (
      output branch_request_i, branch_is_taken_i, branch_is_not_taken_i,
      output branch_source_i, branch_pc_i,
      output branch_is_call_i, branch_is_ret_i, branch_is_jmp_i,
      output pc_f_i,
      input  next_pc_f_o, next_taken_f_o
   );

   modport slave (
      input  branch_request_i, branch_is_taken_i, branch_is_not_taken_i,
      input  branch_source_i, branch_pc_i,
      input  branch_is_call_i, branch_is_ret_i, branch_is_jmp_i,
      input  pc_f_i,
      output next_pc_f_o, next_taken_f_o
   );
endinterface

// File: rtl/biriscv_branch_predictor.sv
// Direct-mapped BTB (2-bit counters) plus return address stack.
// Ports: clk_i, rst_i (async, active high), bus (slave): resolution in, fetch PC in, prediction out.
module biriscv_branch_predictor #(
   parameter int NUM_BTB_ENTRIES = 32,
   parameter int RAS_DEPTH       = 8,
   parameter bit ENABLE_PRED     = 1'b1
) (
   input logic                         clk_i,
   input logic                         rst_i,
   biriscv_branch_predictor_if.slave   bus
);

   localparam int IDX_W = $clog2(NUM_BTB_ENTRIES);
   localparam int TAG_W = 30 - IDX_W;
   localparam int RAS_W = $clog2(RAS_DEPTH);

   typedef enum logic [1:0] {
      T_COND = 2'd0,
      T_CALL = 2'd1,
      T_RET  = 2'd2,
      T_JMP  = 2'd3
   } br_type_t;

   logic             valid_q [NUM_BTB_ENTRIES];
   logic [1:0]       ctr_q   [NUM_BTB_ENTRIES];
   logic [TAG_W-1:0] tag_q   [NUM_BTB_ENTRIES];
   logic [29:0]      tgt_q   [NUM_BTB_ENTRIES];
   br_type_t         type_q  [NUM_BTB_ENTRIES];

   logic [31:0]      ras_q   [RAS_DEPTH];
   logic [RAS_W-1:0] ras_ptr_q;
   logic [RAS_W:0]   ras_cnt_q;

   // ---------------- lookup ----------------
   logic [IDX_W-1:0] idx_f;
   logic [TAG_W-1:0] tag_f;
   logic             hit_f;
   logic             taken_f;
   logic [31:0]      ras_top;
   logic [31:0]      tgt_f;

   assign idx_f   = bus.pc_f_i[IDX_W+1:2];
   assign tag_f   = bus.pc_f_i[31:IDX_W+2];
   assign hit_f   = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
   // ptr points at the next free slot; top of stack is one below
   assign ras_top = ras_q[ras_ptr_q - RAS_W'(1)];

   assign taken_f = ENABLE_PRED && hit_f &&
                    ((type_q[idx_f] != T_COND) || ctr_q[idx_f][1]);

   assign tgt_f = ((type_q[idx_f] == T_RET) && (ras_cnt_q != '0)) ?
                  ras_top : {tgt_q[idx_f], 2'b00};

   assign bus.next_taken_f_o = taken_f;
   assign bus.next_pc_f_o    = taken_f ? tgt_f : bus.pc_f_i + 32'd4;

   // ---------------- update ----------------
   logic [IDX_W-1:0] idx_u;
   logic [TAG_W-1:0] tag_u;
   logic             hit_u;
   logic             upd;
   br_type_t         type_u;

   assign idx_u = bus.branch_source_i[IDX_W+1:2];
   assign tag_u = bus.branch_source_i[31:IDX_W+2];
   assign hit_u = valid_q[idx_u] && (tag_q[idx_u] == tag_u);
   // exactly one outcome flag must be set for the resolution to count
   assign upd   = bus.branch_request_i &&
                  (bus.branch_is_taken_i ^ bus.branch_is_not_taken_i);

   always_comb begin
      type_u = T_COND;
      if (bus.branch_is_call_i)     type_u = T_CALL;
      else if (bus.branch_is_ret_i) type_u = T_RET;
      else if (bus.branch_is_jmp_i) type_u = T_JMP;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_BTB_ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            ctr_q[i]   <= 2'b00;
         end
      end else if (upd) begin
         if (hit_u) begin
            if (bus.branch_is_taken_i) begin
               if (ctr_q[idx_u] != 2'b11)
                  ctr_q[idx_u] <= ctr_q[idx_u] + 2'b01;
            end else if (ctr_q[idx_u] != 2'b00) begin
               ctr_q[idx_u] <= ctr_q[idx_u] - 2'b01;
            end
         end else if (bus.branch_is_taken_i) begin
            valid_q[idx_u] <= 1'b1;
            ctr_q[idx_u]   <= 2'b10;
         end
      end
   end

   // Tag/target/type carry no reset; valid gates their use.
   always_ff @(posedge clk_i) begin
      if (upd && bus.branch_is_taken_i) begin
         tag_q[idx_u]  <= tag_u;
         tgt_q[idx_u]  <= bus.branch_pc_i[31:2];
         type_q[idx_u] <= type_u;
      end
   end

   // ---------------- return address stack ----------------
   logic ras_push;
   logic ras_pop;

   assign ras_push = upd && bus.branch_is_call_i;
   assign ras_pop  = upd && !bus.branch_is_call_i &&
                     bus.branch_is_ret_i && (ras_cnt_q != '0);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ras_ptr_q <= '0;
         ras_cnt_q <= '0;
      end else if (ras_push) begin
         ras_ptr_q <= ras_ptr_q + RAS_W'(1);
         if (ras_cnt_q != (RAS_W+1)'(RAS_DEPTH))
            ras_cnt_q <= ras_cnt_q + (RAS_W+1)'(1);
      end else if (ras_pop) begin
         ras_ptr_q <= ras_ptr_q - RAS_W'(1);
         ras_cnt_q <= ras_cnt_q - (RAS_W+1)'(1);
      end
   end

   // Overflow simply wraps ptr, overwriting the oldest entry.
   always_ff @(posedge clk_i) begin
      if (ras_push)
         ras_q[ras_ptr_q] <= bus.branch_source_i + 32'd4;
   end

   logic unused_bits;
   assign unused_bits = ^{bus.pc_f_i[1:0], bus.branch_pc_i[1:0]};

endmodule

// File: tb/tb_biriscv_branch_predictor.sv
// Scoreboard bench for biriscv_branch_predictor.
// Stimulus pushes expected predictions; a negedge monitor pops and compares.
module tb_biriscv_branch_predictor;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   biriscv_branch_predictor_if bus();

   biriscv_branch_predictor #(
      .NUM_BTB_ENTRIES (512),
      .RAS_DEPTH       (8),
      .ENABLE_PRED     (1'b1)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   typedef struct {
      string       name;
      logic        taken;
      logic [31:0] npc;
   } exp_t;

   exp_t sb[$];
   logic chk = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   always @(negedge clk) begin : mon
      exp_t e;
      if (chk) begin
         n_tests++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_underflow: got no expectation, want one");
         end else begin
            e = sb.pop_front();
            if (bus.next_taken_f_o !== e.taken ||
                bus.next_pc_f_o !== e.npc) begin
               n_fail++;
               $display("FAIL %s: got taken=%0b pc=%h, want taken=%0b pc=%h",
                        e.name, bus.next_taken_f_o, bus.next_pc_f_o,
                        e.taken, e.npc);
            end
         end
      end
   end

   task automatic cyc(input logic req, input logic tk, input logic nt,
                      input logic call, input logic ret, input logic jmp,
                      input logic [31:0] src, input logic [31:0] tgt,
                      input logic [31:0] pc, input bit en, input string nm,
                      input logic etk, input logic [31:0] enpc);
      bus.branch_request_i      = req;
      bus.branch_is_taken_i     = tk;
      bus.branch_is_not_taken_i = nt;
      bus.branch_is_call_i      = call;
      bus.branch_is_ret_i       = ret;
      bus.branch_is_jmp_i       = jmp;
      bus.branch_source_i       = src;
      bus.branch_pc_i           = tgt;
      bus.pc_f_i                = pc;
      if (en) begin
         sb.push_back('{name: nm, taken: etk, npc: enpc});
         chk = 1'b1;
      end else begin
         chk = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic look(input string nm, input logic [31:0] pc,
                       input logic etk, input logic [31:0] enpc);
      cyc(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, pc, 1'b1, nm, etk, enpc);
   endtask

   task automatic res(input logic tk, input logic nt, input logic call,
                      input logic ret, input logic jmp,
                      input logic [31:0] src, input logic [31:0] tgt);
      cyc(1, tk, nt, call, ret, jmp, src, tgt, 32'h0, 1'b0, "", 1'b0, 32'h0);
   endtask

   initial begin
      logic [31:0] e;
      bus.branch_request_i      = 1'b0;
      bus.branch_is_taken_i     = 1'b0;
      bus.branch_is_not_taken_i = 1'b0;
      bus.branch_is_call_i      = 1'b0;
      bus.branch_is_ret_i       = 1'b0;
      bus.branch_is_jmp_i       = 1'b0;
      bus.branch_source_i       = 32'h0;
      bus.branch_pc_i           = 32'h0;
      bus.pc_f_i                = 32'h0;
      @(posedge clk);
      #1;

      // reset behaviour
      look("in_reset", 32'h8000_0000, 1'b0, 32'h8000_0004);
      rst = 1'b0;
      look("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);
      look("cold_0x100", 32'h100, 1'b0, 32'h104);

      // conditional branch counter training
      res(1, 0, 0, 0, 0, 32'h100, 32'h180);
      look("cond_alloc", 32'h100, 1'b1, 32'h180);
      cyc(1, 0, 1, 0, 0, 0, 32'h100, 32'h104, 32'h100, 1'b1,
          "same_cycle_old", 1'b1, 32'h180);
      look("cond_ctr01", 32'h100, 1'b0, 32'h104);
      res(1, 0, 0, 0, 0, 32'h100, 32'h180);
      look("cond_ctr10", 32'h100, 1'b1, 32'h180);
      res(1, 0, 0, 0, 0, 32'h100, 32'h180);
      res(1, 0, 0, 0, 0, 32'h100, 32'h180);
      res(0, 1, 0, 0, 0, 32'h100, 32'h104);
      look("cond_sat_hi", 32'h100, 1'b1, 32'h180);
      res(0, 1, 0, 0, 0, 32'h100, 32'h104);
      res(0, 1, 0, 0, 0, 32'h100, 32'h104);
      res(0, 1, 0, 0, 0, 32'h100, 32'h104);
      res(1, 0, 0, 0, 0, 32'h100, 32'h180);
      look("cond_sat_lo", 32'h100, 1'b0, 32'h104);
      res(1, 0, 0, 0, 0, 32'h100, 32'h180);
      cyc(1, 1, 1, 0, 0, 0, 32'h100, 32'h999, 32'h0, 1'b0, "", 1'b0, 32'h0);
      cyc(1, 0, 0, 0, 0, 0, 32'h100, 32'h999, 32'h0, 1'b0, "", 1'b0, 32'h0);
      look("bad_flags_ign", 32'h100, 1'b1, 32'h180);
      res(0, 1, 0, 0, 0, 32'h140, 32'h144);
      look("miss_nt_nowr", 32'h140, 1'b0, 32'h144);

      // unconditional jump ignores counter
      res(1, 0, 0, 0, 1, 32'h600, 32'h700);
      res(0, 1, 0, 0, 1, 32'h600, 32'h604);
      res(0, 1, 0, 0, 1, 32'h600, 32'h604);
      look("jmp_uncond", 32'h600, 1'b1, 32'h700);

      // call / return
      res(1, 0, 1, 0, 0, 32'h200, 32'h1234);
      res(1, 0, 0, 1, 0, 32'h480, 32'h204);
      look("ret_empty_btb", 32'h480, 1'b1, 32'h204);
      res(1, 0, 1, 0, 0, 32'h300, 32'h2000);
      look("ret_ras_0x304", 32'h480, 1'b1, 32'h304);
      look("call_entry", 32'h200, 1'b1, 32'h1234);
      res(1, 0, 1, 1, 0, 32'h210, 32'h1234);
      look("call_wins", 32'h480, 1'b1, 32'h214);

      // RAS overflow and drain
      for (int k = 0; k < 9; k++)
         res(1, 0, 1, 0, 0, 32'h1000 + 32'(k) * 32'h10, 32'h6000);
      look("ras_full_top", 32'h480, 1'b1, 32'h1084);
      for (int r = 1; r <= 9; r++) begin
         res(1, 0, 0, 1, 0, 32'h480, 32'h204);
         e = (r < 8) ? 32'h1084 - 32'(r) * 32'h10 : 32'h204;
         look($sformatf("ras_pop%0d", r), 32'h480, 1'b1, e);
      end
      res(1, 0, 1, 0, 0, 32'h3000, 32'h5000);
      look("ras_after_empty", 32'h480, 1'b1, 32'h3004);

      // aliasing on the same index
      res(1, 0, 0, 0, 0, 32'h100, 32'h180);
      res(1, 0, 0, 0, 0, 32'h900, 32'h900);
      look("alias_evicted", 32'h100, 1'b0, 32'h104);
      look("alias_hit", 32'h900, 1'b1, 32'h900);

      // asynchronous reset mid-cycle
      bus.branch_request_i = 1'b0;
      bus.pc_f_i = 32'h900;
      sb.push_back('{name: "async_rst", taken: 1'b0, npc: 32'h904});
      chk = 1'b1;
      #2 rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      look("post_rst_900", 32'h900, 1'b0, 32'h904);
      look("post_rst_480", 32'h480, 1'b0, 32'h484);
      look("post_rst_600", 32'h600, 1'b0, 32'h604);

      chk = 1'b0;
      repeat (2) @(posedge clk);
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL sb_leftover: got %0d pending, want 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
